proc_mem_responder: RTL and testbench

- Responder end of the processor's imem/dmem request interface.
- Word-addressed RAM with two ports:
  - imem: read-only, combinational response.
  - dmem: combinational read, synchronous write.
- A handshake loader port fills the RAM before the processor is released (LOAD state). The RUN state then serves processor requests and keeps access counters and a sticky error flag.

---
 rtl/proc_mem_responder_pkg.sv | 21 ++
 rtl/proc_mem_responder_mem_array_2r1w.sv | 28 ++
 rtl/proc_mem_responder.sv | 146 ++++++++++++++
 tb/tb_proc_mem_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_mem_responder_pkg.sv
// rtl/proc_mem_responder_pkg.sv - shared constants and state encoding for the memory responder
package proc_mem_responder_pkg;

  // memreq type field values
  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  // Responder state: loader owns the RAM in LOAD, processor owns it in RUN
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } resp_state_t;

  // Byte address is legal when word aligned and inside a RAM of 2**aw words
  function automatic logic addr_legal(input logic [31:0] addr, input int aw);
    logic [31:0] upper;
    upper = addr >> (aw + 2);
    return (addr[1:0] == 2'b00) && (upper == 32'd0);
  endfunction

endpackage

// File: rtl/proc_mem_responder_mem_array_2r1w.sv
// rtl/proc_mem_responder_mem_array_2r1w.sv - word RAM with two combinational reads and one synchronous write
module mem_array_2r1w #(
  parameter int p_nwords = 256
) (
  input  logic                        clk,
  input  logic [$clog2(p_nwords)-1:0] rd0_idx,
  output logic [31:0]                 rd0_data,
  input  logic [$clog2(p_nwords)-1:0] rd1_idx,
  output logic [31:0]                 rd1_data,
  input  logic                        wr_en,
  input  logic [$clog2(p_nwords)-1:0] wr_idx,
  input  logic [31:0]                 wr_data
);

  logic [31:0] mem [p_nwords];

  // Reads see the array as it stands before this cycle's write
  assign rd0_data = mem[rd0_idx];
  assign rd1_data = mem[rd1_idx];

  // Single write port; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/proc_mem_responder.sv
// rtl/proc_mem_responder.sv - imem/dmem responder with loader front end, counters and sticky error
module proc_mem_responder
  import proc_mem_responder_pkg::*;
#(
  parameter int p_nwords = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_val,
  output logic        ld_rdy,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_done,
  output logic        proc_go,
  input  logic        imemreq_val,
  input  logic [31:0] imemreq_addr,
  output logic [31:0] imemresp_data,
  input  logic        dmemreq_val,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic [31:0] dmemresp_rdata,
  output logic        err,
  output logic [31:0] imem_count,
  output logic [31:0] dmem_rd_count,
  output logic [31:0] dmem_wr_count
);

  localparam int AW = $clog2(p_nwords);

  resp_state_t state;

  logic          in_run;
  logic          ld_ok;
  logic          imem_ok;
  logic          dmem_ok;
  logic          ld_fire;
  logic          dmem_rd_fire;
  logic          dmem_wr_fire;
  logic          err_set;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic [31:0]   rd0_data;
  logic [31:0]   rd1_data;

  assign in_run  = (state == RUN);
  assign ld_ok   = addr_legal(ld_addr, AW);
  assign imem_ok = addr_legal(imemreq_addr, AW);
  assign dmem_ok = addr_legal(dmemreq_addr, AW);

  assign ld_fire      = !in_run && ld_val;
  assign dmem_rd_fire = in_run && dmemreq_val && (dmemreq_type == MEMREQ_READ);
  assign dmem_wr_fire = in_run && dmemreq_val && (dmemreq_type == MEMREQ_WRITE);

  // Any illegal access on any port this cycle; several at once still set err once
  assign err_set = (ld_fire && !ld_ok)
                 || (in_run && imemreq_val && !imem_ok)
                 || (in_run && dmemreq_val && !dmem_ok);

  // Write port owner follows the state, so loader and dmem never collide
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (!rst) begin
      if (ld_fire && ld_ok) begin
        wr_en   = 1'b1;
        wr_idx  = ld_addr[AW+1:2];
        wr_data = ld_data;
      end else if (dmem_wr_fire && dmem_ok) begin
        wr_en   = 1'b1;
        wr_idx  = dmemreq_addr[AW+1:2];
        wr_data = dmemreq_wdata;
      end
    end
  end

  mem_array_2r1w #(
    .p_nwords (p_nwords)
  ) u_mem (
    .clk      (clk),
    .rd0_idx  (imemreq_addr[AW+1:2]),
    .rd0_data (rd0_data),
    .rd1_idx  (dmemreq_addr[AW+1:2]),
    .rd1_data (rd1_data),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data)
  );

  // Responses are zero unless a legal request is being served in RUN
  always_comb begin
    imemresp_data  = 32'd0;
    dmemresp_rdata = 32'd0;
    if (in_run && imemreq_val && imem_ok) begin
      imemresp_data = rd0_data;
    end
    if (dmem_rd_fire && dmem_ok) begin
      dmemresp_rdata = rd1_data;
    end
  end

  // State machine with registered handshake outputs, sticky error and access counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOAD;
      ld_rdy        <= 1'b1;
      proc_go       <= 1'b0;
      err           <= 1'b0;
      imem_count    <= 32'd0;
      dmem_rd_count <= 32'd0;
      dmem_wr_count <= 32'd0;
    end else begin
      case (state)
        LOAD: begin
          if (ld_done) begin
            state   <= RUN;
            ld_rdy  <= 1'b0;
            proc_go <= 1'b1;
          end
        end
        RUN: begin
          if (imemreq_val) begin
            imem_count <= imem_count + 32'd1;
          end
          if (dmem_rd_fire) begin
            dmem_rd_count <= dmem_rd_count + 32'd1;
          end
          if (dmem_wr_fire) begin
            dmem_wr_count <= dmem_wr_count + 32'd1;
          end
        end
        default: begin
          state   <= LOAD;
          ld_rdy  <= 1'b1;
          proc_go <= 1'b0;
        end
      endcase
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_proc_mem_responder.sv
// tb/tb_proc_mem_responder.sv - directed self-checking bench for proc_mem_responder
module tb_proc_mem_responder;

  logic        clk;
  logic        rst;
  logic        ld_val;
  logic        ld_rdy;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_done;
  logic        proc_go;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic [31:0] imemresp_data;
  logic        dmemreq_val;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic [31:0] dmemresp_rdata;
  logic        err;
  logic [31:0] imem_count;
  logic [31:0] dmem_rd_count;
  logic [31:0] dmem_wr_count;

  int n_cmp;
  int n_bad;

  proc_mem_responder #(.p_nwords(256)) dut (
    .clk            (clk),
    .rst            (rst),
    .ld_val         (ld_val),
    .ld_rdy         (ld_rdy),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .ld_done        (ld_done),
    .proc_go        (proc_go),
    .imemreq_val    (imemreq_val),
    .imemreq_addr   (imemreq_addr),
    .imemresp_data  (imemresp_data),
    .dmemreq_val    (dmemreq_val),
    .dmemreq_type   (dmemreq_type),
    .dmemreq_addr   (dmemreq_addr),
    .dmemreq_wdata  (dmemreq_wdata),
    .dmemresp_rdata (dmemresp_rdata),
    .err            (err),
    .imem_count     (imem_count),
    .dmem_rd_count  (dmem_rd_count),
    .dmem_wr_count  (dmem_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ld_val        = 1'b0;
    ld_addr       = 32'd0;
    ld_data       = 32'd0;
    ld_done       = 1'b0;
    imemreq_val   = 1'b0;
    imemreq_addr  = 32'd0;
    dmemreq_val   = 1'b0;
    dmemreq_type  = 1'b0;
    dmemreq_addr  = 32'd0;
    dmemreq_wdata = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    ld_val  = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
  endtask

  task automatic fetch(input logic [31:0] a);
    imemreq_val  = 1'b1;
    imemreq_addr = a;
    #1;
  endtask

  task automatic dread(input logic [31:0] a);
    dmemreq_val  = 1'b1;
    dmemreq_type = 1'b0;
    dmemreq_addr = a;
    #1;
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [31:0] d);
    dmemreq_val   = 1'b1;
    dmemreq_type  = 1'b1;
    dmemreq_addr  = a;
    dmemreq_wdata = d;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("reset_ld_rdy", {31'd0, ld_rdy}, 32'd1);
    check("reset_proc_go", {31'd0, proc_go}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_imem_count", imem_count, 32'd0);
    check("reset_dmem_rd_count", dmem_rd_count, 32'd0);
    check("reset_dmem_wr_count", dmem_wr_count, 32'd0);

    load_word(32'h0, 32'h0000_0013);
    load_word(32'h4, 32'h00A0_0093);
    load_word(32'h8, 32'h2222_2222);
    load_word(32'h10, 32'h0);

    // processor traffic during LOAD is isolated
    fetch(32'h0);
    dwrite(32'h8, 32'h5);
    check("load_iso_imem_resp", imemresp_data, 32'd0);
    check("load_iso_dmem_resp", dmemresp_rdata, 32'd0);
    tick();
    check("load_iso_imem_count", imem_count, 32'd0);
    check("load_iso_wr_count", dmem_wr_count, 32'd0);
    check("load_iso_err", {31'd0, err}, 32'd0);

    ld_done = 1'b1;
    tick();
    check("run_proc_go", {31'd0, proc_go}, 32'd1);
    check("run_ld_rdy", {31'd0, ld_rdy}, 32'd0);

    fetch(32'h4);
    check("fetch_0x4", imemresp_data, 32'h00A0_0093);
    tick();
    check("fetch_count_1", imem_count, 32'd1);

    fetch(32'h8);
    check("mem2_unchanged", imemresp_data, 32'h2222_2222);
    tick();

    // store with same-cycle fetch of the same word sees the old value
    dwrite(32'h10, 32'hDEAD_BEEF);
    fetch(32'h10);
    check("store_cycle_fetch_old", imemresp_data, 32'd0);
    check("store_cycle_dmem_resp", dmemresp_rdata, 32'd0);
    tick();
    check("store_wr_count", dmem_wr_count, 32'd1);

    dread(32'h10);
    check("load_after_store", dmemresp_rdata, 32'hDEAD_BEEF);
    tick();
    check("load_rd_count", dmem_rd_count, 32'd1);
    check("imem_count_3", imem_count, 32'd3);
    check("no_err_yet", {31'd0, err}, 32'd0);

    // loader is ignored in RUN
    ld_val  = 1'b1;
    ld_addr = 32'h10;
    ld_data = 32'h99;
    tick();
    dread(32'h10);
    check("loader_ignored_run", dmemresp_rdata, 32'hDEAD_BEEF);
    tick();

    // out-of-range dmem read
    dread(32'h400);
    check("oob_read_resp", dmemresp_rdata, 32'd0);
    tick();
    check("oob_read_err", {31'd0, err}, 32'd1);
    fetch(32'h0);
    check("oob_ram_intact", imemresp_data, 32'h0000_0013);
    tick();

    // reset mid-RUN with a competing store to word 0
    for (int i = 0; i < 5; i++) begin
      fetch(32'h4);
      tick();
    end
    rst = 1'b1;
    dwrite(32'h0, 32'h77);
    tick();
    rst = 1'b0;
    check("midrst_ld_rdy", {31'd0, ld_rdy}, 32'd1);
    check("midrst_proc_go", {31'd0, proc_go}, 32'd0);
    check("midrst_imem_count", imem_count, 32'd0);
    check("midrst_wr_count", dmem_wr_count, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);

    ld_done = 1'b1;
    tick();
    fetch(32'h0);
    check("rerun_mem0_kept", imemresp_data, 32'h0000_0013);
    tick();

    // misaligned store is dropped and flags err
    dwrite(32'h6, 32'hAAAA_AAAA);
    tick();
    check("misaligned_err", {31'd0, err}, 32'd1);
    fetch(32'h4);
    check("misaligned_dropped", imemresp_data, 32'h00A0_0093);
    tick();

    for (int i = 0; i < 10; i++) begin
      dread(32'h0);
      tick();
    end
    check("err_sticky", {31'd0, err}, 32'd1);
    check("rd_count_10", dmem_rd_count, 32'd10);

    // illegal loader address in LOAD
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load_word(32'h400, 32'h1);
    check("ld_oob_err", {31'd0, err}, 32'd1);

    // write and done in the same cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ld_val  = 1'b1;
    ld_addr = 32'hC;
    ld_data = 32'h1234;
    ld_done = 1'b1;
    tick();
    check("ld_done_same_go", {31'd0, proc_go}, 32'd1);
    fetch(32'hC);
    check("ld_done_same_data", imemresp_data, 32'h0000_1234);
    tick();
    check("ld_done_same_err", {31'd0, err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
